// File: rtl/reg_bank_arbiter.sv
// Register bank with a single write port shared by NREQ requesters.
// Round-robin grant, optional lock bursts, and a combinational read port.
module reg_bank_arbiter #(
    parameter int unsigned    NREQ        = 4,
    parameter int unsigned    W           = 32,
    parameter int unsigned    NREGS       = 8,
    parameter int unsigned    AW          = 3,
    parameter int unsigned    IW          = 2,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset_p,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*W-1:0]    req_data,
    input  logic [AW-1:0]        raddr,
    output logic [W-1:0]         rdata,
    output logic                 locked,
    output logic [IW-1:0]        owner
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    regs_q [NREGS];

    logic [NREQ-1:0] grant_c;
    logic            fire_c;
    logic [IW-1:0]   fire_idx_c;
    logic            found_c;
    int unsigned     scan_idx_c;
    logic [AW-1:0]   wr_addr_c;
    logic [W-1:0]    wr_data_c;

    // Grant: owner only while locked, otherwise first valid requester from ptr.
    always_comb begin
        grant_c    = '0;
        fire_idx_c = '0;
        found_c    = 1'b0;
        scan_idx_c = 0;
        if (!reset_p) begin
            if (state_q == ST_LOCKED) begin
                grant_c[owner_q] = req_val[owner_q];
                fire_idx_c       = owner_q;
            end else begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    scan_idx_c = (32'(ptr_q) + k) % NREQ;
                    if (!found_c && req_val[IW'(scan_idx_c)]) begin
                        found_c                  = 1'b1;
                        fire_idx_c               = IW'(scan_idx_c);
                        grant_c[IW'(scan_idx_c)] = 1'b1;
                    end
                end
            end
        end
    end

    assign fire_c    = |grant_c;
    assign wr_addr_c = req_addr[fire_idx_c*AW +: AW];
    assign wr_data_c = req_data[fire_idx_c*W +: W];

    // Lock FSM and round-robin pointer next state.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (fire_c) begin
            if (req_lock[fire_idx_c]) begin
                state_d = ST_LOCKED;
                owner_d = fire_idx_c;
            end else begin
                state_d = ST_UNLOCKED;
                owner_d = '0;
                ptr_d   = IW'((32'(fire_idx_c) + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= ST_UNLOCKED;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Out-of-range addresses complete the handshake but write nothing.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else if (fire_c && (32'(wr_addr_c) < NREGS)) begin
            regs_q[wr_addr_c] <= wr_data_c;
        end
    end

    assign rdata   = (32'(raddr) < NREGS) ? regs_q[raddr] : '0;
    assign req_rdy = grant_c;
    assign locked  = (state_q == ST_LOCKED);
    assign owner   = owner_q;

    req_val_known_a: assert property (@(posedge clk) disable iff (reset_p) !$isunknown(req_val));

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares the single write port of an internal bank of NREGS enabled, resettable W-bit registers among NREQ requesters.
- Uses round-robin arbitration with val/rdy handshakes.
- A requester may lock the bank to perform an uninterrupted burst of writes.
- Provides one combinational read port for downstream consumers. Sits between multiple producer units and a shared configuration/state register bank.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 32, register data width
NREGS, 8, number of registers in the bank
AW, 3, register address width; must equal clog2(NREGS)
IW, 2, requester index width; must equal clog2(NREQ)
RESET_VALUE, 0, value loaded into every register on reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset_p  input  1  synchronous active-high reset
req_val  input  NREQ  per-requester write request valid
req_rdy  output  NREQ  per-requester grant; at most one bit set per cycle
req_lock  input  NREQ  per-requester lock request, sampled only on fire
req_addr  input  NREQ*AW  packed; requester i at [i*AW +: AW]
req_data  input  NREQ*W  packed; requester i at [i*W +: W]
raddr  input  AW  read address
rdata  output  W  combinational read data = reg[raddr]
locked  output  1  bank currently locked by a requester
owner  output  IW  lock owner index; valid when locked=1, else 0

Behaviour:
- Reset (reset_p=1 at posedge):
  - All registers load RESET_VALUE. ptr=0, locked=0, owner=0.
  - While reset_p=1, req_rdy is forced to all-zeros, so no fire occurs. Reset overrides any simultaneous request.
  - A lock in progress is abandoned.
- State: ptr (IW bits, round-robin priority head), locked (1 bit), owner (IW bits), register array.
- Grant is combinational from state and req_val:
  - Unlocked: scan i = ptr, ptr+1, ... mod NREQ. The first i with req_val[i]=1 gets req_rdy[i]=1; all others get 0.
  - Locked: req_rdy[owner]=req_val[owner]. All others get 0, even if valid. If the owner is not valid, the bank idles.
  - req_rdy depends on req_val. Requesters must not make req_val depend on req_rdy.
- Fire: fire_i = req_val[i] & req_rdy[i]. At most one fire per cycle.
- Write: on fire by i, reg[req_addr_i] <= req_data_i at the posedge. Write latency is 1 cycle.
- Read: rdata = reg[raddr], purely combinational, with no write bypass. A write becomes visible on rdata the cycle after fire.
- Out-of-range address (req_addr >= NREGS when NREGS is not a power of 2): the write is dropped, but the handshake still completes.
- Pointer update on fire by i:
  - If req_lock[i]=1, ptr is unchanged.
  - Otherwise ptr <= (i+1) mod NREQ.
  - No fire means ptr is unchanged.
- Lock FSM, two states: UNLOCKED and LOCKED(owner).
  - UNLOCKED, fire by i with req_lock[i]=1: go to LOCKED, owner<=i. This write itself is performed.
  - LOCKED, fire by owner with req_lock=1: stay in LOCKED.
  - LOCKED, fire by owner with req_lock=0: go to UNLOCKED, ptr<=(owner+1) mod NREQ. This final write is performed.
  - LOCKED with no fire: stay in LOCKED indefinitely. There is no timeout.
- req_lock is ignored when no fire occurs for that requester.
- Fairness: in UNLOCKED, any continuously valid requester is granted within NREQ fires.
- Outputs locked and owner are registered. They reflect state, not the current cycle's request.
- Assertion (non-synthesis): req_val must not be X at posedge when reset_p=0.

Test Plan:
- Reset, then set raddr=0..7 -> rdata=RESET_VALUE (0) for all addresses; req_rdy=0000; locked=0.
- Hold req_val=1111 for 8 cycles, requester i writes addr=i, data=0x10+i -> grants in order 0,1,2,3,0,1,2,3. One-hot req_rdy each cycle. reg[i]=0x10+i visible on rdata one cycle after each fire.
- Requester 1 fires with lock=1, then req_val=1111 for 3 cycles with requester 1 lock=1,1,0 -> only requester 1 granted for 4 consecutive fires. Then locked=0, and the next grant goes to requester 2.
- Locked by requester 3, owner drops req_val for 5 cycles while others request -> req_rdy=0000 all 5 cycles, no register changes, locked=1, owner=3.
- Locked by requester 0 mid-burst, assert reset_p for 1 cycle with req_val=1111 -> no write that cycle. Afterwards locked=0, ptr=0, all registers = RESET_VALUE, and the next grant goes to requester 0.
- Requester 2 writes addr=5 data=0xDEADBEEF with raddr=5 -> rdata shows the old value in the fire cycle and 0xDEADBEEF in the next cycle.
